overlay_update_scheduler: RTL and testbench
===========================================

Name: overlay_update_scheduler

Overview:
Sequences string updates into a Text_Overlay character buffer and arbitrates between NUM_REQ string sources. It latches the granted string, issues a one-cycle wr_ready, waits for the overlay's write-completion edge, and acknowledges the requester. Updates are committed only at frame boundaries, using the Video_Signal_Generator o_nf pulse. The block also holds the video timing generator in reset until the first buffer load completes.

Parameters:
NUM_REQ, 2, number of string sources; must be >= 1.
NUM_CHAR, 13, characters per string; must match the overlay's NUM_CHAR.
TIMEOUT_CYCLES, 4096, maximum cycles to wait for write completion.

Ports:
i_clk  in  1  pixel clock
i_reset  in  1  asynchronous, active-high reset
i_req  in  NUM_REQ  level request per source; held until that source's o_done
i_strings  in  NUM_REQ*NUM_CHAR*8  source k occupies bits [k*NUM_CHAR*8 +: NUM_CHAR*8]; char 0 in the LSB byte
i_nf  in  1  new-frame pulse from the timing generator
i_wr_completed  in  1  overlay o_wr_completed
o_characters  out  NUM_CHAR*8  overlay i_characters
o_wr_ready  out  1  overlay i_wr_ready; one-cycle pulse
o_gnt  out  NUM_REQ  one-hot current grant
o_done  out  NUM_REQ  one-cycle acknowledge to the granted source
o_busy  out  1  high in any state except IDLE
o_video_hold  out  1  drives the timing-generator reset
o_timeout  out  1  sticky completion-timeout flag

Behaviour:
Reset values (asynchronous, active-high)
- State = IDLE.
- o_characters = all 8'h20.
- o_wr_ready, o_gnt, o_done, o_busy, o_timeout = 0.
- o_video_hold = 1.
- Round-robin pointer = 0; timer = 0; completion edge register = 0.
- A reset asserted mid-operation aborts the transaction and issues no o_done.

State machine
- IDLE
  - If any i_req is set, grant the first set bit at or after the pointer, modulo NUM_REQ; o_gnt updates next cycle.
  - If o_video_hold = 1, go to LATCH (initial load, no frame wait).
  - Otherwise go to WAIT_FRAME.
- WAIT_FRAME
  - If i_nf = 1, go to LATCH.
  - If i_req[gnt] drops, clear o_gnt, go to IDLE, no o_done, pointer unchanged.
  - A simultaneous i_nf and request drop resolves to abort.
- LATCH
  - o_characters <= granted slice; go to ISSUE.
  - The transaction is committed from here; later i_req changes are ignored.
- ISSUE
  - o_wr_ready = 1 for exactly this cycle; clear timer; go to WAIT_DONE.
- WAIT_DONE
  - Completion = i_wr_completed & ~i_wr_completed_q, where the register is sampled every cycle. A level that is already high does not count.
  - On completion: o_done[gnt] pulses for 1 cycle, o_video_hold <= 0, pointer <= (gnt+1) mod NUM_REQ, o_gnt <= 0, go to IDLE.
  - If timer reaches TIMEOUT_CYCLES-1 without completion: o_timeout <= 1 (sticky until reset), o_done still pulses, o_video_hold is unchanged, go to IDLE.

Latency and request rules
- Minimum latency from the i_nf cycle (in WAIT_FRAME) to o_wr_ready is 2 cycles.
- From reset release with a request present, o_wr_ready rises on cycle 3.
- A new request is accepted no earlier than the cycle after o_done.
- Requests arriving during a transaction wait; none are dropped.
- With NUM_REQ = 1 the pointer stays 0.
- o_characters holds its last value between transactions.

Width rules
- Pointer width = max(1, $clog2(NUM_REQ)).
- Timer width = $clog2(TIMEOUT_CYCLES+1); the timer saturates and never wraps.

Decomposition:
- Package overlay_sched_pkg:
  - State enum {IDLE, WAIT_FRAME, LATCH, ISSUE, WAIT_DONE}.
  - CHAR_W = 8.
  - SPACE_CHAR = 8'h20.
- One sub-module, rr_arbiter: parameter N; inputs req[N] and ptr; outputs one-hot gnt and index. It is purely combinational; the pointer register stays in the scheduler.

Test Plan:
1. Reset release, i_req = 2'b01, source 0 = "Hello, world!" -> o_wr_ready pulses on cycle 3 with no i_nf needed. After the i_wr_completed edge: o_done = 2'b01, o_video_hold 1->0, o_characters = "Hello, world!".
2. After load, source 1 = "Hello, hello!" requests, i_nf arrives 100 cycles later -> o_wr_ready exactly 2 cycles after i_nf, completion gives o_done = 2'b10. No o_wr_ready before i_nf.
3. Both sources request continuously for 4 transactions -> grant order 0,1,0,1, and o_gnt is never multi-hot.
4. Source 0 granted and in WAIT_FRAME drops i_req before i_nf -> returns to IDLE, no o_done, no o_wr_ready, o_characters unchanged.
5. i_wr_completed held high through ISSUE, never toggling, TIMEOUT_CYCLES = 16 -> o_timeout = 1 after 16 cycles in WAIT_DONE, o_done pulses, and o_timeout stays 1 through later transactions.
6. i_reset asserted during WAIT_DONE -> outputs return to reset values asynchronously within the same cycle: o_characters all 8'h20, o_video_hold = 1, no o_done.

Source files
------------

// File: rtl/overlay_update_scheduler_pkg.sv
// Shared types and constants for the overlay update scheduler.
package overlay_sched_pkg;

    localparam int unsigned CHAR_W = 8;
    localparam logic [CHAR_W-1:0] SPACE_CHAR = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        LATCH,
        ISSUE,
        WAIT_DONE
    } state_t;

    // Index width for n sources; a single source still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/overlay_update_scheduler_if.sv
// Request/string/overlay handshake bundle between sources, scheduler and overlay.
interface overlay_update_scheduler_if #(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned NUM_CHAR = 13
);
    import overlay_sched_pkg::*;

    logic [NUM_REQ-1:0]               i_req;
    logic [NUM_REQ*NUM_CHAR*CHAR_W-1:0] i_strings;
    logic                             i_nf;
    logic                             i_wr_completed;
    logic [NUM_CHAR*CHAR_W-1:0]       o_characters;
    logic                             o_wr_ready;
    logic [NUM_REQ-1:0]               o_gnt;
    logic [NUM_REQ-1:0]               o_done;
    logic                             o_busy;
    logic                             o_video_hold;
    logic                             o_timeout;

    // Scheduler side.
    modport slave (
        input  i_req, i_strings, i_nf, i_wr_completed,
        output o_characters, o_wr_ready, o_gnt, o_done, o_busy, o_video_hold, o_timeout
    );

    // Sources / overlay / timing side.
    modport master (
        output i_req, i_strings, i_nf, i_wr_completed,
        input  o_characters, o_wr_ready, o_gnt, o_done, o_busy, o_video_hold, o_timeout
    );

endinterface

// File: rtl/overlay_update_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer.
module rr_arbiter
    import overlay_sched_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] w_pos;
    logic             w_found;

    // Scan from the pointer, wrapping modulo N, and take the first hit.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_pos   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            w_pos = IDX_W'((32'(i_ptr) + k) % N);
            if (!w_found && i_req[w_pos]) begin
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/overlay_update_scheduler.sv
// Arbitrates string sources and commits one string per frame into the overlay buffer.
module overlay_update_scheduler
    import overlay_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned NUM_CHAR       = 13,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    overlay_update_scheduler_if.slave bus
);

    localparam int unsigned PTR_W   = idx_width(NUM_REQ);
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned STR_W   = NUM_CHAR * CHAR_W;

    state_t               r_state, w_state_d;
    logic [PTR_W-1:0]     r_ptr, w_ptr_d;
    logic [PTR_W-1:0]     r_gnt_idx, w_gnt_idx_d;
    logic [NUM_REQ-1:0]   r_gnt, w_gnt_d;
    logic [STR_W-1:0]     r_chars, w_chars_d;
    logic                 r_hold, w_hold_d;
    logic                 r_timeout, w_timeout_d;
    logic [TIMER_W-1:0]   r_timer, w_timer_d;
    logic                 r_wr_comp_q;

    logic [NUM_REQ-1:0]   w_arb_gnt;
    logic [PTR_W-1:0]     w_arb_idx;
    logic [PTR_W-1:0]     w_ptr_next;
    logic [NUM_REQ-1:0]   w_done;
    logic                 w_complete;
    logic                 w_req_granted;
    logic [STR_W-1:0]     w_str [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_str
        assign w_str[g] = bus.i_strings[g*STR_W +: STR_W];
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (PTR_W)
    ) u_arb (
        .i_req (bus.i_req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx)
    );

    // Only a rising edge counts; a level already high at ISSUE never completes.
    assign w_complete    = bus.i_wr_completed & ~r_wr_comp_q;
    assign w_req_granted = |(bus.i_req & r_gnt);
    assign w_ptr_next    = (r_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;

    // Next-state and transaction bookkeeping.
    always_comb begin
        w_state_d   = r_state;
        w_ptr_d     = r_ptr;
        w_gnt_idx_d = r_gnt_idx;
        w_gnt_d     = r_gnt;
        w_chars_d   = r_chars;
        w_hold_d    = r_hold;
        w_timeout_d = r_timeout;
        w_timer_d   = r_timer;
        w_done      = '0;
        unique case (r_state)
            IDLE: begin
                if (|bus.i_req) begin
                    w_gnt_d     = w_arb_gnt;
                    w_gnt_idx_d = w_arb_idx;
                    // The very first load skips the frame wait: video is still held.
                    w_state_d   = r_hold ? LATCH : WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                // Request drop wins over a coincident frame pulse.
                if (!w_req_granted) begin
                    w_gnt_d   = '0;
                    w_state_d = IDLE;
                end else if (bus.i_nf) begin
                    w_state_d = LATCH;
                end
            end
            LATCH: begin
                w_chars_d = w_str[r_gnt_idx];
                w_state_d = ISSUE;
            end
            ISSUE: begin
                w_timer_d = '0;
                w_state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (w_complete) begin
                    w_done    = r_gnt;
                    w_hold_d  = 1'b0;
                    w_ptr_d   = w_ptr_next;
                    w_gnt_d   = '0;
                    w_state_d = IDLE;
                end else if (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    w_done      = r_gnt;
                    w_timeout_d = 1'b1;
                    w_ptr_d     = w_ptr_next;
                    w_gnt_d     = '0;
                    w_state_d   = IDLE;
                end else if (r_timer != '1) begin
                    w_timer_d = r_timer + 1'b1;
                end
            end
            default: begin
                w_gnt_d   = '0;
                w_state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gnt_idx   <= '0;
            r_gnt       <= '0;
            r_chars     <= {NUM_CHAR{SPACE_CHAR}};
            r_hold      <= 1'b1;
            r_timeout   <= 1'b0;
            r_timer     <= '0;
            r_wr_comp_q <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_ptr       <= w_ptr_d;
            r_gnt_idx   <= w_gnt_idx_d;
            r_gnt       <= w_gnt_d;
            r_chars     <= w_chars_d;
            r_hold      <= w_hold_d;
            r_timeout   <= w_timeout_d;
            r_timer     <= w_timer_d;
            r_wr_comp_q <= bus.i_wr_completed;
        end
    end

    assign bus.o_characters = r_chars;
    assign bus.o_wr_ready   = (r_state == ISSUE);
    assign bus.o_gnt        = r_gnt;
    // Acknowledge in the completion cycle so the source drops i_req before IDLE samples it.
    assign bus.o_done       = w_done;
    assign bus.o_busy       = (r_state != IDLE);
    assign bus.o_video_hold = r_hold;
    assign bus.o_timeout    = r_timeout;

endmodule

// File: tb/tb_overlay_update_scheduler.sv
// Directed bench with a cycle-indexed transaction model for overlay_update_scheduler.
module tb_overlay_update_scheduler;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic nf = 1'b0;
    logic wc = 1'b0;
    logic [103:0] src_str [2];
    logic [103:0] spaces = {13{8'h20}};
    logic [1:0] one = 2'b01;

    int checks = 0;
    int failures = 0;

    overlay_update_scheduler_if #(.NUM_REQ(2), .NUM_CHAR(13)) bus ();

    assign bus.i_req          = req;
    assign bus.i_strings      = {src_str[1], src_str[0]};
    assign bus.i_nf           = nf;
    assign bus.i_wr_completed = wc;

    overlay_update_scheduler #(
        .NUM_REQ        (2),
        .NUM_CHAR       (13),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [103:0] pack(input string s);
        logic [103:0] v;
        v = {13{8'h20}};
        for (int i = 0; i < 13 && i < s.len(); i++) v[i*8 +: 8] = s[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- Transaction model ----------------
    // cyc numbers the clock intervals; an interval starts at a rising edge.
    int cyc = 0;
    int m_src = -1;      // granted source, -1 when nothing is granted
    int m_wr_at = -1;    // interval in which the write strobe is due
    int m_ptr = 0;
    bit m_wf = 0;        // granted but waiting for a frame boundary
    bit m_hold = 1;
    bit m_timeout = 0;
    bit m_prev_wc = 0;
    logic [103:0] m_chars = {13{8'h20}};

    function automatic bit m_edge();
        return wc && !m_prev_wc;
    endfunction

    function automatic bit m_fire();
        return (m_src >= 0) && (m_wr_at >= 0) && (cyc > m_wr_at) &&
               (m_edge() || cyc == m_wr_at + TO);
    endfunction

    function automatic int pick(input logic [1:0] r, input int p);
        for (int i = 0; i < 2; i++) if (r[(p + i) % 2]) return (p + i) % 2;
        return -1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_src = -1; m_wr_at = -1; m_ptr = 0; m_wf = 0;
                m_hold = 1; m_timeout = 0; m_prev_wc = 0; m_chars = spaces;
            end else begin
                if (m_fire()) begin
                    if (m_edge()) m_hold = 0;
                    else m_timeout = 1;
                    m_ptr = (m_src + 1) % 2;
                    m_src = -1;
                    m_wr_at = -1;
                end else if (m_src < 0) begin
                    m_src = pick(req, m_ptr);
                    if (m_src >= 0) begin
                        if (m_hold) m_wr_at = cyc + 2;
                        else m_wf = 1;
                    end
                end else if (m_wf) begin
                    if (!req[m_src]) begin
                        m_src = -1;
                        m_wf = 0;
                    end else if (nf) begin
                        m_wf = 0;
                        m_wr_at = cyc + 2;
                    end
                end
                // Characters change when the interval just before the strobe ends.
                if (m_src >= 0 && m_wr_at == cyc + 1) m_chars = src_str[m_src];
                m_prev_wc = wc;
            end
            cyc++;
        end
    end

    // Compare every output against the model on each falling edge.
    initial begin
        logic [1:0] e_gnt;
        logic [1:0] e_done;
        forever begin
            @(negedge clk);
            if (rst) begin
                e_gnt = 2'b00;
                e_done = 2'b00;
                chk("cyc_chars", bus.o_characters, spaces);
                chk("cyc_wr_ready", bus.o_wr_ready, 1'b0);
                chk("cyc_hold", bus.o_video_hold, 1'b1);
                chk("cyc_timeout", bus.o_timeout, 1'b0);
                chk("cyc_busy", bus.o_busy, 1'b0);
            end else begin
                e_gnt = (m_src >= 0) ? (one << m_src) : 2'b00;
                e_done = (m_src >= 0 && m_fire()) ? (one << m_src) : 2'b00;
                chk("cyc_chars", bus.o_characters, m_chars);
                chk("cyc_wr_ready", bus.o_wr_ready, (cyc == m_wr_at));
                chk("cyc_hold", bus.o_video_hold, m_hold);
                chk("cyc_timeout", bus.o_timeout, m_timeout);
                chk("cyc_busy", bus.o_busy, (m_src >= 0));
            end
            chk("cyc_gnt", bus.o_gnt, e_gnt);
            chk("cyc_done", bus.o_done, e_done);
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic wait_wr(output int n);
        n = 0;
        while (bus.o_wr_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("wr_ready_seen", bus.o_wr_ready, 1'b1);
    endtask

    task automatic pulse_nf();
        nf = 1'b1;
        tick();
        nf = 1'b0;
    endtask

    // Raise the overlay completion edge now; request lines become 'after' next interval.
    task automatic complete(input int k, input logic [1:0] after);
        wc = 1'b1;
        #1;
        chk("done_pulse", bus.o_done, one << k);
        tick();
        wc = 1'b0;
        req = after;
    endtask

    function automatic int idx_of(input logic [1:0] g);
        case (g)
            2'b01:   return 0;
            2'b10:   return 1;
            default: return -1;
        endcase
    endfunction

    initial begin
        int n;
        int m;
        int pulses;
        int got;
        int exp_ord [4] = '{0, 1, 0, 1};

        src_str[0] = pack("Hello, world!");
        src_str[1] = pack("Hello, hello!");

        // 1: initial load straight out of reset, no frame pulse needed.
        req = 2'b01;
        repeat (3) tick();
        rst = 1'b0;
        wait_wr(n);
        chk("t1_latency", n, 2);
        chk("t1_hold_before", bus.o_video_hold, 1'b1);
        repeat (2) tick();
        complete(0, 2'b00);
        chk("t1_hold_after", bus.o_video_hold, 1'b0);
        chk("t1_chars", bus.o_characters, pack("Hello, world!"));
        chk("t1_char0", bus.o_characters[7:0], 8'h48);

        // 2: later update waits for the frame pulse.
        req = 2'b10;
        pulses = 0;
        repeat (100) begin
            tick();
            if (bus.o_wr_ready) pulses++;
        end
        chk("t2_no_early_wr", pulses, 0);
        nf = 1'b1;
        tick();
        nf = 1'b0;
        wait_wr(m);
        chk("t2_nf_to_wr", m + 1, 2);
        repeat (2) tick();
        complete(1, 2'b00);
        chk("t2_chars", bus.o_characters, pack("Hello, hello!"));

        // 3: both sources keep requesting; grants alternate.
        req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            repeat (4) tick();
            pulse_nf();
            wait_wr(n);
            got = idx_of(bus.o_gnt);
            chk("t3_order", got, exp_ord[t]);
            repeat (2) tick();
            complete(exp_ord[t], (t == 3) ? 2'b00 : (2'b11 & ~(one << exp_ord[t])));
            if (t < 3) begin
                tick();
                req = 2'b11;
            end
        end

        // 4: source drops its request while waiting for the frame.
        req = 2'b01;
        repeat (2) tick();
        chk("t4_gnt", bus.o_gnt, 2'b01);
        req = 2'b00;
        repeat (2) tick();
        chk("t4_gnt_clear", bus.o_gnt, 2'b00);
        chk("t4_busy", bus.o_busy, 1'b0);
        chk("t4_chars", bus.o_characters, pack("Hello, hello!"));

        // 5: completion level stuck high, so the write times out.
        wc = 1'b1;
        req = 2'b01;
        repeat (3) tick();
        pulse_nf();
        wait_wr(n);
        n = 0;
        while (bus.o_done === 2'b00 && n < 40) begin
            tick();
            n++;
        end
        chk("t5_timeout_cycles", n, TO);
        chk("t5_done", bus.o_done, 2'b01);
        tick();
        req = 2'b00;
        wc = 1'b0;
        chk("t5_timeout_flag", bus.o_timeout, 1'b1);
        chk("t5_hold", bus.o_video_hold, 1'b0);
        req = 2'b10;
        repeat (3) tick();
        pulse_nf();
        wait_wr(n);
        repeat (2) tick();
        complete(1, 2'b00);
        chk("t5_timeout_sticky", bus.o_timeout, 1'b1);

        // 6: reset in the middle of waiting for completion.
        req = 2'b01;
        repeat (3) tick();
        pulse_nf();
        wait_wr(n);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        chk("t6_chars", bus.o_characters, spaces);
        chk("t6_hold", bus.o_video_hold, 1'b1);
        chk("t6_done", bus.o_done, 2'b00);
        chk("t6_gnt", bus.o_gnt, 2'b00);
        chk("t6_wr", bus.o_wr_ready, 1'b0);
        tick();
        rst = 1'b0;
        req = 2'b00;
        tick();
        chk("t6_timeout_cleared", bus.o_timeout, 1'b0);
        req = 2'b10;
        wait_wr(n);
        chk("t6_reload_latency", n, 2);
        repeat (2) tick();
        complete(1, 2'b00);
        chk("t6_reload_chars", bus.o_characters, pack("Hello, hello!"));
        chk("t6_hold_released", bus.o_video_hold, 1'b0);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish by 300000");
        $fatal(1, "watchdog expired");
    end

endmodule
